// File: rtl/axi_sram_pkg.sv
// axi_sram_pkg: AXI response/burst codes and one-hot FSM encodings
// shared by the AXI SRAM slave and its storage.
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    R_IDLE = 3'b001,
    R_WAIT = 3'b010,
    R_DATA = 3'b100
  } rstate_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_DATA = 3'b010,
    W_RESP = 3'b100
  } wstate_e;

  // bit positions inside both one-hot encodings
  localparam int ST_IDLE = 0;
  localparam int ST_MID  = 1;
  localparam int ST_END  = 2;

  // WRAP and the reserved code step like INCR
  function automatic logic burst_step(input logic [1:0] burst);
    logic step;
    case (burst)
      BURST_FIXED:            step = 1'b0;
      BURST_INCR, BURST_WRAP: step = 1'b1;
      default:                step = 1'b1;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// axi_sram_mem: word-wide SRAM, one byte-strobed write port and one
// registered read port; a same-cycle read of a written word sees old data.
module axi_sram_mem #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [3:0][7:0] mem_q [2**AW];
  logic [31:0]     rdata_q;

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_i[i]) begin
          mem_q[waddr_i][i] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3-style SRAM slave with independent read and
// write burst engines in front of axi_sram_mem.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int MEM_WORDS_LOG2 = 14,
  parameter int R_LATENCY      = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = MEM_WORDS_LOG2;
  localparam int CW =
    (R_LATENCY > 1) ? $clog2(R_LATENCY + 1) : 1;

  rstate_e       r_q;
  logic          arready_q;
  logic          rvalid_q;
  logic          rlast_q;
  logic [3:0]    rid_q;
  logic [AW-1:0] ridx_q;
  logic [7:0]    rlen_q;
  logic [7:0]    rbeat_q;
  logic [1:0]    rburst_q;
  logic [CW-1:0] rwait_q;

  wstate_e       w_q;
  logic          awready_q;
  logic          wready_q;
  logic          bvalid_q;
  logic [3:0]    bid_q;
  logic [1:0]    bresp_q;
  logic [AW-1:0] widx_q;
  logic [7:0]    wlen_q;
  logic [7:0]    wbeat_q;
  logic [1:0]    wburst_q;
  logic          werr_q;

  logic [AW-1:0] rnxt;
  logic [AW-1:0] rld_idx;
  logic          rld;
  logic [AW-1:0] wnxt;
  logic          wbeat;
  logic          wfinal;
  logic          wbad;
  logic          unused_ok;

  assign rnxt = ridx_q + AW'(burst_step(rburst_q));
  assign wnxt = widx_q + AW'(burst_step(wburst_q));

  // the mem output register holds the word on rdata, so it is
  // reloaded only on the first beat or an accepted non-last beat
  assign rld = r_q[ST_END] &&
               (!rvalid_q || (rready && !rlast_q));
  assign rld_idx = rvalid_q ? rnxt : ridx_q;

  assign wbeat  = w_q[ST_MID] && wvalid && wready_q;
  assign wfinal = (wbeat_q == wlen_q);
  assign wbad   = (wlast != wfinal);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_q       <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= '0;
      rwait_q   <= '0;
    end else begin
      unique case (1'b1)
        r_q[ST_IDLE]: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            arready_q <= 1'b0;
            rid_q     <= arid;
            ridx_q    <= araddr[AW+1:2];
            rlen_q    <= arlen;
            rburst_q  <= arburst;
            rwait_q   <= CW'(R_LATENCY);
            if (R_LATENCY == 0) begin
              r_q <= R_DATA;
            end else begin
              r_q <= R_WAIT;
            end
          end
        end
        r_q[ST_MID]: begin
          rwait_q <= rwait_q - CW'(1);
          if (rwait_q == CW'(1)) begin
            r_q <= R_DATA;
          end
        end
        r_q[ST_END]: begin
          if (!rvalid_q) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (rlen_q == 8'd0);
            rbeat_q  <= 8'd0;
          end else if (rready) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_q       <= R_IDLE;
            end else begin
              rbeat_q <= rbeat_q + 8'd1;
              rlast_q <= (rbeat_q + 8'd1 == rlen_q);
              ridx_q  <= rnxt;
            end
          end
        end
        default: r_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_q       <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      widx_q    <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
    end else begin
      unique case (1'b1)
        w_q[ST_IDLE]: begin
          awready_q <= 1'b1;
          if (awvalid && awready_q) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= awid;
            widx_q    <= awaddr[AW+1:2];
            wlen_q    <= awlen;
            wburst_q  <= awburst;
            wbeat_q   <= 8'd0;
            werr_q    <= 1'b0;
            w_q       <= W_DATA;
          end
        end
        w_q[ST_MID]: begin
          if (wbeat) begin
            if (wfinal) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (werr_q || wbad) ?
                          RESP_SLVERR : RESP_OKAY;
              w_q      <= W_RESP;
            end else begin
              wbeat_q <= wbeat_q + 8'd1;
              widx_q  <= wnxt;
              werr_q  <= werr_q || wbad;
            end
          end
        end
        w_q[ST_END]: begin
          if (bready) begin
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awready_q <= 1'b1;
            w_q       <= W_IDLE;
          end
        end
        default: w_q <= W_IDLE;
      endcase
    end
  end

  axi_sram_mem #(
    .AW(AW)
  ) u_mem (
    .clk_i   (aclk),
    .we_i    (wbeat),
    .waddr_i (widx_q),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .re_i    (rld),
    .raddr_i (rld_idx),
    .rdata_o (rdata)
  );

  assign arready = arready_q;
  assign rid     = rid_q;
  assign rresp   = RESP_OKAY;
  assign rlast   = rlast_q;
  assign rvalid  = rvalid_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign bvalid  = bvalid_q;

  assign unused_ok = ^{arsize, awsize, wid,
                       araddr[31:AW+2], araddr[1:0],
                       awaddr[31:AW+2], awaddr[1:0]};

endmodule
